// File: rtl/counter_arb.sv
// counter_arb: round-robin arbiter that lends one shared timeout counter to NUM_REQ requesters.
// Optional RUN-phase watchdog is compiled in with `define COUNTER_ARB_WATCHDOG_EN.
module counter_arb #(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = 8,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_value,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic                     err,
  output logic                     cnt_load,
  output logic [WIDTH-1:0]         cnt_load_value,
  output logic                     cnt_enable,
  input  logic                     cnt_irq
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   r_last_owner;
  logic [IDX_W-1:0]   w_pick;
  logic [IDX_W-1:0]   w_cand;
  logic               w_found;
  logic [NUM_REQ-1:0] w_pick_onehot;
  logic [NUM_REQ-1:0] r_grant;
  logic               w_abort;
  logic [WIDTH-1:0]   w_value [NUM_REQ];

  if (WDOG_CYCLES < 1) begin : g_wdog_cfg_check
    $error("counter_arb: WDOG_CYCLES must be at least 1");
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign w_value[gi]       = req_value[gi*WIDTH +: WIDTH];
    assign w_pick_onehot[gi] = (w_pick == IDX_W'(gi));
  end

  // Round-robin search: the most recent owner gets the lowest priority.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_last_owner;
    w_cand  = r_last_owner;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = IDX_W'((int'(r_last_owner) + k) % NUM_REQ);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  always_comb begin
    w_state_next   = r_state;
    busy           = 1'b1;
    cnt_load       = 1'b0;
    cnt_load_value = '0;
    cnt_enable     = 1'b0;
    done           = '0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_found) w_state_next = S_LOAD;
      end
      S_LOAD: begin
        cnt_load       = 1'b1;
        cnt_load_value = w_value[r_idx];
        w_state_next   = S_RUN;
      end
      S_RUN: begin
        // Terminal count beats both the watchdog and a dropped request.
        cnt_enable = !cnt_irq;
        if (cnt_irq) w_state_next = S_DONE;
        else if (w_abort || !req[r_idx]) w_state_next = S_IDLE;
      end
      S_DONE: begin
        done         = r_grant;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_last_owner <= LAST_INIT;
      r_grant      <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_idx   <= w_pick;
            r_grant <= w_pick_onehot;
          end
        end
        S_RUN: begin
          if (w_state_next == S_IDLE) begin
            r_grant <= '0;
            if (w_abort) r_last_owner <= r_idx;
          end
        end
        S_DONE: begin
          r_grant      <= '0;
          r_last_owner <= r_idx;
        end
        default: ;
      endcase
    end
  end

  assign grant = r_grant;

`ifdef COUNTER_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);

  logic [WD_W-1:0] r_wdog;
  logic            r_err;

  // Counts RUN cycles of the current owner; zero on the first RUN cycle.
  always_ff @(posedge clk) begin
    if (rst || r_state != S_RUN) r_wdog <= '0;
    else                         r_wdog <= r_wdog + 1'b1;
  end

  assign w_abort = (r_state == S_RUN) && !cnt_irq && (r_wdog == WD_W'(WDOG_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= w_abort;
  end

  assign err = r_err;
`else
  assign w_abort = 1'b0;
  assign err     = 1'b0;
`endif

endmodule

// File: doc/counter_arb.md
COUNTER_ARB -- requirements
Module: counter_arb

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one counter instance.
REQ-002 Parameter WIDTH, default 8: counter width; must match the controlled counter.
REQ-003 Parameter WDOG_CYCLES, default 1024: watchdog limit in RUN cycles; used only when the watchdog is compiled in.
REQ-004 clk  input  1  sole clock; all logic on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req  input  NUM_REQ  per-requester timeout request level; the requester holds it until done or abandonment.
REQ-007 req_value  input  NUM_REQ*WIDTH  per-requester start value; slice i = bits [i*WIDTH +: WIDTH].
REQ-008 grant  output  NUM_REQ  one-hot owner of the counter; all zero when idle.
REQ-009 done  output  NUM_REQ  one-cycle pulse to the owner on timeout completion.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 err  output  1  one-cycle watchdog abort pulse.
REQ-012 cnt_load  output  1  drives the counter load input.
REQ-013 cnt_load_value  output  WIDTH  drives the counter load value.
REQ-014 cnt_enable  output  1  drives the counter enable input.
REQ-015 cnt_irq  input  1  counter terminal-count pulse.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, RUN and DONE, encoded in registers.
REQ-017 IDLE: if req is nonzero, SHALL pick owner idx round-robin (search starts at last_owner+1, wraps modulo NUM_REQ), register idx and grant, and go to LOAD; else stay in IDLE.
REQ-018 LOAD (one cycle): cnt_load=1 and cnt_load_value=req_value slice idx, then go to RUN unconditionally.
REQ-019 RUN: cnt_enable = !cnt_irq (combinational), so the counter never advances in the cycle irq is seen.
REQ-020 RUN with cnt_irq=1: go to DONE.
REQ-021 RUN with req[idx]=0 and cnt_irq=0: abandon; go to IDLE with no done pulse and grant cleared.
REQ-022 RUN with cnt_irq=1 and req[idx]=0 in the same cycle: irq wins and done is still pulsed.
REQ-023 DONE (one cycle): done[idx]=1; last_owner<=idx; go to IDLE.
REQ-024 grant SHALL stay stable from LOAD through DONE inclusive, and req changes on non-owners SHALL have no effect until IDLE.
REQ-025 An owner that still holds req in the cycle after done SHALL be re-arbitrated; round-robin gives every other active requester priority first.
REQ-026 cnt_load and cnt_enable SHALL never be high in the same cycle, and both SHALL be 0 outside LOAD and RUN.
REQ-027 cnt_load_value SHALL be 0 outside LOAD.
REQ-028 Minimum request-to-done latency is 3 cycles (IDLE sample, LOAD, one RUN cycle seeing irq), plus the counter run time.

Reset
REQ-029 On rst=1 at a clock edge: state=IDLE, last_owner=NUM_REQ-1 (so requester 0 wins first), and grant, done, busy, err, cnt_load, cnt_enable and cnt_load_value all 0.
REQ-030 Reset during LOAD or RUN SHALL abandon the transfer: no done, and cnt_enable is low from the next cycle.

Configuration
REQ-031 Macro COUNTER_ARB_WATCHDOG_EN.
  - Defined: a RUN-cycle counter clears on entry to RUN. If it reaches WDOG_CYCLES without cnt_irq, the FSM SHALL pulse err for one cycle, skip done, update last_owner and go to IDLE.
  - cnt_irq in the limit cycle wins over the watchdog.
REQ-032 Without the macro, err SHALL be tied to 0 and no watchdog logic SHALL exist.

Verification
(Setup: NUM_REQ=4, WIDTH=8, counter MAX_COUNT=255.)
REQ-033 Single request: req=0001, value 250.
  - Required: grant=0001 one cycle after sample.
  - Required: cnt_load one cycle with value 250.
  - Required: done[0] 8 cycles after sample.
REQ-034 Contention: req=1111 held.
  - Required: grants in order 0001, 0010, 0100, 1000, 0001, with exactly one done per grant.
REQ-035 Abandon: req[2] dropped on the third RUN cycle.
  - Required: IDLE next cycle, no done, cnt_enable low.
  - Required: next grant goes to the requester after index 2.
REQ-036 Simultaneous: req[idx] falls in the same cycle cnt_irq=1.
  - Required: done[idx] is pulsed.
REQ-037 Reset mid-RUN: rst=1 on RUN cycle 2.
  - Required: all outputs 0 next cycle.
  - Required: the next request from 0000 grants requester 0.
REQ-038 Watchdog with COUNTER_ARB_WATCHDOG_EN and WDOG_CYCLES=16: cnt_irq held 0.
  - Required: err pulse after RUN cycle 16, no done, then IDLE.
